// File: rtl/nave_ctrl_if.sv
// Player-ship controller bus: frame strobe, pause, keys and hit in; ship state out to renderer/score.
// Latency: pure wiring, no storage.
// Backpressure: none; frame_tick is a strobe and pausa is the only stall.
interface nave_ctrl_if;
  logic       frame_tick;
  logic       pausa;
  logic [3:0] keysout;
  logic       hit;
  logic [9:0] x_nave;
  logic [9:0] y_nave;
  logic [2:0] speed;
  logic       explodindo;
  logic       visivel;
  logic       lost_life;

  // Stimulus/game side: drives controls, observes ship state.
  modport master (
    output frame_tick, pausa, keysout, hit,
    input  x_nave, y_nave, speed, explodindo, visivel, lost_life
  );

  // Ship controller side.
  modport slave (
    input  frame_tick, pausa, keysout, hit,
    output x_nave, y_nave, speed, explodindo, visivel, lost_life
  );
endinterface

// File: rtl/nave_ctrl.sv
// Player-ship controller: per-frame 2D motion with horizontal acceleration, screen clamping and an ALIVE/EXPLODING/RESPAWN life cycle.
// Latency: all outputs registered; position/state change in the cycle after the advancing frame_tick edge, hit acts on the clock it is seen.
// Backpressure: none; pausa=1 freezes every register, and a hit seen during pause or outside ALIVE is dropped, not queued.
module nave_ctrl #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int SHIP_W         = 45,
  parameter int SHIP_H         = 51,
  parameter int X0             = 320,
  parameter int Y0             = 410,
  parameter int Y_MIN          = 240,
  parameter int MAX_SPEED      = 4,
  parameter int V_STEP         = 2,
  parameter int EXPLODE_FRAMES = 30,
  parameter int INVULN_FRAMES  = 60
) (
  input  logic        CLOCK_50,
  input  logic        resetNave,
  nave_ctrl_if.slave  nave
);

  localparam logic [1:0] ST_ALIVE     = 2'd0;
  localparam logic [1:0] ST_EXPLODING = 2'd1;
  localparam logic [1:0] ST_RESPAWN   = 2'd2;

  // Counter must hold the longer of the two phases and expose bit 2 for the blink.
  localparam int CNT_MAX = (EXPLODE_FRAMES > INVULN_FRAMES) ? EXPLODE_FRAMES : INVULN_FRAMES;
  localparam int CW_RAW  = $clog2(CNT_MAX + 1);
  localparam int CW      = (CW_RAW < 3) ? 3 : CW_RAW;

  // 11-bit arithmetic so x+speed / y+step never wraps before clamping.
  localparam logic [10:0]   X_MAX   = 11'(SCREEN_W - SHIP_W);
  localparam logic [10:0]   Y_MAX   = 11'(SCREEN_H - SHIP_H);
  localparam logic [10:0]   Y_LO    = 11'(Y_MIN);
  localparam logic [10:0]   VSTEP   = 11'(V_STEP);
  localparam logic [9:0]    X_SPAWN = 10'(X0);
  localparam logic [9:0]    Y_SPAWN = 10'(Y0);
  localparam logic [2:0]    SPD_MAX = 3'(MAX_SPEED);
  localparam logic [CW-1:0] CNT_EXP = CW'(EXPLODE_FRAMES);
  localparam logic [CW-1:0] CNT_INV = CW'(INVULN_FRAMES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [2:0]    spd_q, spd_d;
  logic          dir_q, dir_d;       // last horizontal direction: 0 right, 1 left
  logic          lost_q, lost_d;
  logic          expl_q, expl_d;
  logic          vis_q, vis_d;

  logic          adv;
  logic          right_only, left_only, up_only, down_only;
  logic [2:0]    spd_mv;
  logic          dir_mv;
  logic [10:0]   x_ext, y_ext, step_ext, x_sum, y_sum;
  logic [10:0]   x_mv, y_mv;

  // Decode frame advance and the mutually exclusive key directions.
  always_comb begin
    adv        = nave.frame_tick & ~nave.pausa;
    right_only = nave.keysout[0] & ~nave.keysout[1];
    left_only  = nave.keysout[1] & ~nave.keysout[0];
    up_only    = nave.keysout[2] & ~nave.keysout[3];
    down_only  = nave.keysout[3] & ~nave.keysout[2];
  end

  // Candidate speed: ramp while the same direction is held, restart at 1 on a new direction.
  always_comb begin
    spd_mv = 3'd0;
    dir_mv = dir_q;
    if (right_only || left_only) begin
      dir_mv = left_only;
      if ((spd_q != 3'd0) && (dir_q == left_only)) begin
        spd_mv = (spd_q >= SPD_MAX) ? SPD_MAX : spd_q + 3'd1;
      end else begin
        spd_mv = 3'd1;
      end
    end
  end

  // Candidate position: new speed applied this frame, clamped to the playfield.
  always_comb begin
    x_ext    = {1'b0, x_q};
    y_ext    = {1'b0, y_q};
    step_ext = {8'd0, spd_mv};
    x_sum    = x_ext + step_ext;
    y_sum    = y_ext + VSTEP;
    x_mv     = x_ext;
    y_mv     = y_ext;
    if (right_only) begin
      x_mv = (x_sum > X_MAX) ? X_MAX : x_sum;
    end else if (left_only) begin
      x_mv = (x_ext < step_ext) ? 11'd0 : x_ext - step_ext;
    end
    if (up_only) begin
      y_mv = (y_ext < Y_LO + VSTEP) ? Y_LO : y_ext - VSTEP;
    end else if (down_only) begin
      y_mv = (y_sum > Y_MAX) ? Y_MAX : y_sum;
    end
  end

  // Life-cycle FSM; a hit in ALIVE takes priority over a same-cycle frame advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    spd_d   = spd_q;
    dir_d   = dir_q;
    lost_d  = 1'b0;
    case (state_q)
      ST_ALIVE: begin
        if (nave.hit && !nave.pausa) begin
          state_d = ST_EXPLODING;
          cnt_d   = CNT_EXP;
          spd_d   = 3'd0;
          lost_d  = 1'b1;
        end else if (adv) begin
          x_d   = x_mv[9:0];
          y_d   = y_mv[9:0];
          spd_d = spd_mv;
          dir_d = dir_mv;
        end
      end
      ST_EXPLODING: begin
        if (adv) begin
          if (cnt_q == CNT_ONE) begin
            state_d = ST_RESPAWN;
            x_d     = X_SPAWN;
            y_d     = Y_SPAWN;
            spd_d   = 3'd0;
            cnt_d   = CNT_INV;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_RESPAWN: begin
        if (adv) begin
          x_d   = x_mv[9:0];
          y_d   = y_mv[9:0];
          spd_d = spd_mv;
          dir_d = dir_mv;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_ALIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_ALIVE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sprite flags derived from next state so they register alongside it.
  always_comb begin
    expl_d = (state_d == ST_EXPLODING);
    case (state_d)
      ST_EXPLODING: vis_d = 1'b0;
      ST_RESPAWN:   vis_d = cnt_d[2];
      default:      vis_d = 1'b1;
    endcase
  end

  // State registers with asynchronous active-high reset to the spawn point.
  always_ff @(posedge CLOCK_50 or posedge resetNave) begin
    if (resetNave) begin
      state_q <= ST_ALIVE;
      cnt_q   <= '0;
      x_q     <= X_SPAWN;
      y_q     <= Y_SPAWN;
      spd_q   <= 3'd0;
      dir_q   <= 1'b0;
      lost_q  <= 1'b0;
      expl_q  <= 1'b0;
      vis_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      spd_q   <= spd_d;
      dir_q   <= dir_d;
      lost_q  <= lost_d;
      expl_q  <= expl_d;
      vis_q   <= vis_d;
    end
  end

  assign nave.x_nave     = x_q;
  assign nave.y_nave     = y_q;
  assign nave.speed      = spd_q;
  assign nave.explodindo = expl_q;
  assign nave.visivel    = vis_q;
  assign nave.lost_life  = lost_q;

endmodule

// File: tb/tb_nave_ctrl.sv
// Bench for nave_ctrl: directed scenarios plus random play against a frame-level ship model.
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: none; stimulus is applied one clock at a time.
module tb_nave_ctrl;

  localparam int XMAX = 640 - 45;
  localparam int YMAX = 480 - 51;
  localparam int YTOP = 240;

  logic CLOCK_50 = 1'b0;
  logic resetNave = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  nave_ctrl_if bus ();

  nave_ctrl dut (
    .CLOCK_50  (CLOCK_50),
    .resetNave (resetNave),
    .nave      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference model: plain integers, one call per clock.
  int m_x, m_y, m_spd, m_dir, m_mode, m_cnt, m_lost;   // m_mode: 0 alive, 1 exploding, 2 respawn

  task automatic model_reset();
    m_x = 320; m_y = 410; m_spd = 0; m_dir = 0; m_mode = 0; m_cnt = 0; m_lost = 0;
  endtask

  task automatic model_move(input logic [3:0] k);
    int d;
    if (k[0] != k[1]) begin
      d = k[1] ? 1 : 0;
      if (m_spd != 0 && d == m_dir) m_spd = (m_spd + 1 > 4) ? 4 : m_spd + 1;
      else m_spd = 1;
      m_dir = d;
      if (k[0]) m_x = (m_x + m_spd > XMAX) ? XMAX : m_x + m_spd;
      else      m_x = (m_x < m_spd) ? 0 : m_x - m_spd;
    end else begin
      m_spd = 0;
    end
    if (k[2] && !k[3])      m_y = (m_y - 2 < YTOP) ? YTOP : m_y - 2;
    else if (k[3] && !k[2]) m_y = (m_y + 2 > YMAX) ? YMAX : m_y + 2;
  endtask

  task automatic model_clock(input logic t, input logic pz, input logic [3:0] k, input logic h);
    m_lost = 0;
    if (pz) return;
    if (m_mode == 0 && h) begin
      m_mode = 1; m_cnt = 30; m_spd = 0; m_lost = 1;
    end else if (t) begin
      if (m_mode == 1) begin
        if (m_cnt == 1) begin
          m_mode = 2; m_cnt = 60; m_x = 320; m_y = 410; m_spd = 0;
        end else m_cnt--;
      end else begin
        model_move(k);
        if (m_mode == 2) begin
          if (m_cnt == 1) begin m_mode = 0; m_cnt = 0; end
          else m_cnt--;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_model(input string tag);
    int vis;
    vis = (m_mode == 0) ? 1 : (m_mode == 1) ? 0 : ((m_cnt >> 2) & 1);
    chk({tag, ".x"},    16'(bus.x_nave),     16'(m_x));
    chk({tag, ".y"},    16'(bus.y_nave),     16'(m_y));
    chk({tag, ".spd"},  16'(bus.speed),      16'(m_spd));
    chk({tag, ".expl"}, 16'(bus.explodindo), 16'(m_mode == 1));
    chk({tag, ".vis"},  16'(bus.visivel),    16'(vis));
    chk({tag, ".lost"}, 16'(bus.lost_life),  16'(m_lost));
  endtask

  task automatic step(input string tag, input logic t, input logic pz, input logic [3:0] k, input logic h);
    bus.frame_tick = t;
    bus.pausa      = pz;
    bus.keysout    = k;
    bus.hit        = h;
    @(posedge CLOCK_50);
    model_clock(t, pz, k, h);
    #1;
    check_model(tag);
  endtask

  initial begin
    int exp_spd[5];
    logic [3:0] rk;
    exp_spd = '{1, 2, 3, 4, 4};
    bus.frame_tick = 1'b0;
    bus.pausa      = 1'b0;
    bus.keysout    = 4'd0;
    bus.hit        = 1'b0;
    model_reset();

    // Reset values, checked while reset is still held.
    #1 resetNave = 1'b1;
    #2;
    chk("rst.x",    16'(bus.x_nave),     16'd320);
    chk("rst.y",    16'(bus.y_nave),     16'd410);
    chk("rst.spd",  16'(bus.speed),      16'd0);
    chk("rst.vis",  16'(bus.visivel),    16'd1);
    chk("rst.expl", 16'(bus.explodindo), 16'd0);
    chk("rst.lost", 16'(bus.lost_life),  16'd0);
    @(negedge CLOCK_50);
    resetNave = 1'b0;

    // Acceleration to the right, then release and a single left tick.
    for (int i = 0; i < 5; i++) begin
      step("accel", 1'b1, 1'b0, 4'b0001, 1'b0);
      chk("accel.spd_seq", 16'(bus.speed), 16'(exp_spd[i]));
    end
    chk("accel.x334", 16'(bus.x_nave), 16'd334);
    step("release", 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("release.spd0", 16'(bus.speed), 16'd0);
    step("left1", 1'b1, 1'b0, 4'b0010, 1'b0);
    chk("left1.spd", 16'(bus.speed), 16'd1);
    chk("left1.x",   16'(bus.x_nave), 16'd333);
    step("idle", 1'b0, 1'b0, 4'b0010, 1'b0);

    // Horizontal clamps at both screen edges.
    for (int i = 0; i < 80; i++) step("right_edge", 1'b1, 1'b0, 4'b0001, 1'b0);
    chk("right_edge.x595", 16'(bus.x_nave), 16'd595);
    step("right_hold", 1'b1, 1'b0, 4'b0001, 1'b0);
    chk("right_hold.x595", 16'(bus.x_nave), 16'd595);
    for (int i = 0; i < 160; i++) step("left_edge", 1'b1, 1'b0, 4'b0010, 1'b0);
    chk("left_edge.x0", 16'(bus.x_nave), 16'd0);

    // Vertical clamps, then pause freezing everything including hit.
    for (int i = 0; i < 200; i++) step("up", 1'b1, 1'b0, 4'b0100, 1'b0);
    chk("up.y240", 16'(bus.y_nave), 16'd240);
    for (int i = 0; i < 200; i++) step("down", 1'b1, 1'b0, 4'b1000, 1'b0);
    chk("down.y429", 16'(bus.y_nave), 16'd429);
    for (int i = 0; i < 5; i++) step("pause", 1'b1, 1'b1, 4'b0101, 1'b1);
    chk("pause.x",    16'(bus.x_nave),     16'd0);
    chk("pause.y",    16'(bus.y_nave),     16'd429);
    chk("pause.expl", 16'(bus.explodindo), 16'd0);

    // Hit together with a tick: hit wins, no move, single lost_life pulse.
    step("pre_hit", 1'b1, 1'b0, 4'b0001, 1'b0);
    step("hit", 1'b1, 1'b0, 4'b0001, 1'b1);
    chk("hit.lost",  16'(bus.lost_life),  16'd1);
    chk("hit.x",     16'(bus.x_nave),     16'd1);
    chk("hit.expl",  16'(bus.explodindo), 16'd1);
    step("hit_after", 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("hit_after.lost", 16'(bus.lost_life), 16'd0);
    for (int i = 0; i < 29; i++) begin
      rk = 4'($urandom);
      step("exploding", 1'b1, 1'b0, rk, 1'($urandom));
    end
    chk("exploding.still", 16'(bus.explodindo), 16'd1);
    step("respawn_entry", 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("respawn.x", 16'(bus.x_nave), 16'd320);
    chk("respawn.y", 16'(bus.y_nave), 16'd410);
    for (int i = 0; i < 59; i++) step("respawn", 1'b1, 1'b0, 4'b0000, 1'b1);
    chk("respawn.no_pulse", 16'(bus.lost_life), 16'd0);
    step("alive_again", 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("alive_again.vis", 16'(bus.visivel), 16'd1);

    // Reset in the middle of EXPLODING: immediate spawn state, no pulse.
    for (int i = 0; i < 6; i++) step("wander", 1'b1, 1'b0, 4'b0101, 1'b0);
    step("hit2", 1'b0, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) step("expl2", 1'b1, 1'b0, 4'b0000, 1'b0);
    #3 resetNave = 1'b1;
    model_reset();
    #1;
    chk("midrst.x",    16'(bus.x_nave),     16'd320);
    chk("midrst.y",    16'(bus.y_nave),     16'd410);
    chk("midrst.expl", 16'(bus.explodindo), 16'd0);
    chk("midrst.vis",  16'(bus.visivel),    16'd1);
    chk("midrst.lost", 16'(bus.lost_life),  16'd0);
    @(negedge CLOCK_50);
    resetNave = 1'b0;

    // Random play against the model.
    for (int i = 0; i < 3000; i++) begin
      rk = 4'($urandom);
      step("rand", ($urandom_range(3) == 0), ($urandom_range(7) == 0), rk, ($urandom_range(39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
